// File: rtl/pll_drp_pkg.sv
// Shared definitions for the PLLE2 DRP reconfiguration controller.
//   state_t     : controller FSM states
//   addr_map    : output select -> {reg1, reg2} DRP addresses
//   div_encode  : divide value -> {high, low, edge, no_count} fields
//   req_valid   : legality check for an incoming request
package pll_drp_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RST,
    S_RD1,
    S_RD1_W,
    S_WR1,
    S_WR1_W,
    S_RD2,
    S_RD2_W,
    S_WR2,
    S_WR2_W,
    S_RELEASE,
    S_WAIT_LOCK,
    S_DONE
  } state_t;

  // Bits of each clock register that belong to other PLL settings and must survive the write.
  localparam logic [15:0] KEEP_REG1 = 16'hF000;
  localparam logic [15:0] KEEP_REG2 = 16'hFF00;

  localparam logic [2:0] SEL_INVALID = 3'd7;
  localparam logic [7:0] DIVIDE_MAX  = 8'd128;

  typedef struct packed {
    logic [6:0] reg1;
    logic [6:0] reg2;
  } drp_regs_t;

  typedef struct packed {
    logic [5:0] high;
    logic [5:0] low;
    logic       edge_flag;
    logic       no_count;
  } div_enc_t;

  function automatic drp_regs_t addr_map(input logic [2:0] sel);
    drp_regs_t r;
    case (sel)
      3'd0:    r = '{reg1: 7'h08, reg2: 7'h09};
      3'd1:    r = '{reg1: 7'h0A, reg2: 7'h0B};
      3'd2:    r = '{reg1: 7'h0C, reg2: 7'h0D};
      3'd3:    r = '{reg1: 7'h0E, reg2: 7'h0F};
      3'd4:    r = '{reg1: 7'h10, reg2: 7'h11};
      3'd5:    r = '{reg1: 7'h06, reg2: 7'h07};
      3'd6:    r = '{reg1: 7'h14, reg2: 7'h15};
      default: r = '{reg1: 7'h00, reg2: 7'h00};
    endcase
    return r;
  endfunction

  // high/low are truncated to 6 bits so a count of 64 encodes as 0.
  function automatic div_enc_t div_encode(input logic [7:0] d);
    div_enc_t e;
    e.high      = 6'(d >> 1);
    e.low       = 6'(d - (d >> 1));
    e.edge_flag = d[0];
    e.no_count  = (d == 8'd1);
    return e;
  endfunction

  function automatic logic req_valid(input logic [2:0] sel, input logic [7:0] d);
    return (sel != SEL_INVALID) && (d != 8'd0) && (d <= DIVIDE_MAX);
  endfunction

endpackage

// File: rtl/pll_drp_reconfig.sv
// Runtime divider reconfiguration for a PLLE2 through its DRP port.
// One request at a time: hold the PLL in reset, read-modify-write the two
// clock registers of the selected output, release the PLL and wait for lock.
//
// Ports
//   refclk                 : clock, also the PLL DCLK
//   rst                    : synchronous active-high reset
//   cfg_valid/cfg_ready    : request handshake (ready only in IDLE)
//   cfg_sel, cfg_divide    : target output (0-5 CLKOUTn, 6 CLKFBOUT) and divide value
//   busy, done, err        : status; done/err are one-cycle pulses
//   drp_addr/di/en/we      : DRP master outputs
//   drp_rdata, drp_rdy     : DRP DO / DRDY
//   pll_rst, pll_locked    : PLL reset and lock
//
// state       | meaning
// ------------+---------------------------------------------
// IDLE        | ready for a request
// RST         | PLL reset asserted, prepare first access
// RD1/RD1_W   | read reg1 / wait for DRDY
// WR1/WR1_W   | write merged reg1 / wait for DRDY
// RD2/RD2_W   | read reg2 / wait for DRDY
// WR2/WR2_W   | write merged reg2 / wait for DRDY
// RELEASE     | PLL reset deasserted
// WAIT_LOCK   | wait for LOCKED or lock timeout
// DONE        | one-cycle completion pulse (err on failure)
module pll_drp_reconfig
  import pll_drp_pkg::*;
#(
  parameter int LOCK_TIMEOUT = 65536,
  parameter int DRDY_TIMEOUT = 64
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [2:0]  cfg_sel,
  input  logic [7:0]  cfg_divide,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [6:0]  drp_addr,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_rdata,
  output logic        drp_en,
  output logic        drp_we,
  input  logic        drp_rdy,
  output logic        pll_rst,
  input  logic        pll_locked
);

  localparam int CNT_MAX = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DRDY_TC = CNT_W'(DRDY_TIMEOUT - 1);
  // The RELEASE cycle already has the PLL out of reset, so it counts toward the lock budget.
  localparam logic [CNT_W-1:0] LOCK_TC = CNT_W'(LOCK_TIMEOUT - 2);

  state_t           state, state_next;
  logic [2:0]       sel_q;
  logic [7:0]       div_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt;

  logic        accept, in_wait, drp_tmo, lock_tmo, fail_now;
  drp_regs_t   regs;
  div_enc_t    enc;

  logic        cfg_ready_d, busy_d, done_d, err_d, drp_en_d, drp_we_d, pll_rst_d;
  logic [6:0]  drp_addr_d;
  logic [15:0] drp_di_d;

  assign accept   = cfg_valid & cfg_ready;
  assign in_wait  = (state == S_RD1_W) || (state == S_WR1_W) ||
                    (state == S_RD2_W) || (state == S_WR2_W);
  assign drp_tmo  = in_wait && !drp_rdy && (cnt == DRDY_TC);
  assign lock_tmo = (state == S_WAIT_LOCK) && !pll_locked && (cnt == LOCK_TC);
  assign fail_now = (state == S_IDLE && accept && !req_valid(cfg_sel, cfg_divide)) ||
                    drp_tmo || lock_tmo;
  assign regs     = addr_map(sel_q);
  assign enc      = div_encode(div_q);

  // State register
  always_ff @(posedge refclk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (accept) state_next = req_valid(cfg_sel, cfg_divide) ? S_RST : S_DONE;
      S_RST:       state_next = S_RD1;
      S_RD1:       state_next = S_RD1_W;
      S_RD1_W:     if (drp_rdy) state_next = S_WR1; else if (drp_tmo) state_next = S_RELEASE;
      S_WR1:       state_next = S_WR1_W;
      S_WR1_W:     if (drp_rdy) state_next = S_RD2; else if (drp_tmo) state_next = S_RELEASE;
      S_RD2:       state_next = S_RD2_W;
      S_RD2_W:     if (drp_rdy) state_next = S_WR2; else if (drp_tmo) state_next = S_RELEASE;
      S_WR2:       state_next = S_WR2_W;
      S_WR2_W:     if (drp_rdy || drp_tmo) state_next = S_RELEASE;
      // A failed DRP access skips the lock wait.
      S_RELEASE:   state_next = err_q ? S_DONE : S_WAIT_LOCK;
      S_WAIT_LOCK: if (pll_locked || lock_tmo) state_next = S_DONE;
      S_DONE:      state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // Output logic: outputs are registered from the next state so they line up
  // with the state they belong to and have clean reset values.
  always_comb begin
    cfg_ready_d = (state_next == S_IDLE);
    busy_d      = (state_next != S_IDLE);
    done_d      = (state_next == S_DONE);
    err_d       = (state_next == S_DONE) && (err_q || fail_now);
    drp_en_d    = (state_next == S_RD1) || (state_next == S_WR1) ||
                  (state_next == S_RD2) || (state_next == S_WR2);
    drp_we_d    = (state_next == S_WR1) || (state_next == S_WR2);
    pll_rst_d   = (state_next inside {S_RST, S_RD1, S_RD1_W, S_WR1, S_WR1_W,
                                      S_RD2, S_RD2_W, S_WR2, S_WR2_W});
    drp_addr_d  = drp_addr;
    if (state_next == S_RD1) drp_addr_d = regs.reg1;
    if (state_next == S_RD2) drp_addr_d = regs.reg2;
    // drp_di doubles as the read-data capture: the merged write word is built
    // on DRDY of the read and then held through the following write.
    drp_di_d    = drp_di;
    if (state == S_RD1_W && drp_rdy)
      drp_di_d = (drp_rdata & KEEP_REG1) | {4'b0000, enc.high, enc.low};
    if (state == S_RD2_W && drp_rdy)
      drp_di_d = (drp_rdata & KEEP_REG2) | {8'h00, enc.edge_flag, enc.no_count, 6'b000000};
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      cfg_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      drp_en    <= 1'b0;
      drp_we    <= 1'b0;
      pll_rst   <= 1'b1;
      drp_addr  <= '0;
      drp_di    <= '0;
    end else begin
      cfg_ready <= cfg_ready_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      drp_en    <= drp_en_d;
      drp_we    <= drp_we_d;
      pll_rst   <= pll_rst_d;
      drp_addr  <= drp_addr_d;
      drp_di    <= drp_di_d;
    end
  end

  // Request capture, sticky failure flag and the shared timeout counter.
  always_ff @(posedge refclk) begin
    if (rst) begin
      sel_q <= '0;
      div_q <= '0;
      err_q <= 1'b0;
      cnt   <= '0;
    end else begin
      if (accept) begin
        sel_q <= cfg_sel;
        div_q <= cfg_divide;
      end
      if (fail_now)    err_q <= 1'b1;
      else if (accept) err_q <= 1'b0;
      if (state_next != state)                  cnt <= '0;
      else if (in_wait || state == S_WAIT_LOCK) cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pll_drp_reconfig.sv
module tb_pll_drp_reconfig;

  localparam int LOCK_TO = 16;
  localparam int DRDY_TO = 8;

  logic        refclk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [2:0]  cfg_sel = '0;
  logic [7:0]  cfg_divide = '0;
  logic        busy, done, err;
  logic [6:0]  drp_addr;
  logic [15:0] drp_di;
  logic [15:0] drp_rdata = '0;
  logic        drp_en, drp_we;
  logic        drp_rdy = 1'b0;
  logic        pll_rst;
  logic        pll_locked = 1'b0;

  pll_drp_reconfig #(.LOCK_TIMEOUT(LOCK_TO), .DRDY_TIMEOUT(DRDY_TO)) dut (
    .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_sel(cfg_sel), .cfg_divide(cfg_divide), .busy(busy), .done(done), .err(err),
    .drp_addr(drp_addr), .drp_di(drp_di), .drp_rdata(drp_rdata), .drp_en(drp_en),
    .drp_we(drp_we), .drp_rdy(drp_rdy), .pll_rst(pll_rst), .pll_locked(pll_locked)
  );

  always #5 refclk = ~refclk;

  int cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // kind: 0 = DRP read, 1 = DRP write, 2 = done pulse
  typedef struct {
    int          kind;
    logic [6:0]  addr;
    logic [15:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];

  task automatic push(input int kind, input logic [6:0] a, input logic [15:0] d, input logic e);
    exp_t x;
    x.kind = kind; x.addr = a; x.data = d; x.err = e;
    sb.push_back(x);
  endtask

  typedef struct {
    logic [2:0]  sel;
    logic [7:0]  div;
    logic [15:0] rd1, rd2;
    logic [6:0]  a1;
    logic [15:0] w1, w2;
  } vec_t;

  task automatic push_accesses(input vec_t v);
    push(0, v.a1, 16'h0, 1'b0);
    push(1, v.a1, v.w1, 1'b0);
    push(0, v.a1 + 7'd1, 16'h0, 1'b0);
    push(1, v.a1 + 7'd1, v.w2, 1'b0);
  endtask

  // Monitor: pops the scoreboard on every DRP pulse and every done pulse.
  int   n_access = 0, n_done = 0;
  int   t_first_en = 0, t_rst_rise = 0, t_rst_fall = 0, t_lock = 0, t_done = 0, t_wr2 = 0;
  bit   first_en_seen = 0, rst_hi_seen = 0, lock_seen = 0;
  logic pll_rst_prev = 1'b1;
  exp_t mon_x;

  always @(negedge refclk) begin
    if (drp_en === 1'b1) begin
      n_access++;
      if (!first_en_seen) begin t_first_en = cyc; first_en_seen = 1; end
      if (drp_we && drp_addr[0]) t_wr2 = cyc;
      chk("pll_rst_during_access", pll_rst, 1);
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_access: addr 0x%0h we %0d with nothing expected", drp_addr, drp_we);
      end else begin
        mon_x = sb.pop_front();
        chk("access_kind", drp_we ? 1 : 0, mon_x.kind);
        chk("drp_addr", drp_addr, mon_x.addr);
        if (mon_x.kind == 1) chk("drp_di", drp_di, mon_x.data);
      end
    end
    if (done === 1'b1) begin
      n_done++;
      t_done = cyc;
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_done: err %0d with nothing expected", err);
      end else begin
        mon_x = sb.pop_front();
        chk("done_kind", 2, mon_x.kind);
        chk("err", err, mon_x.err);
        chk("pll_rst_at_done", pll_rst, 0);
        chk("busy_at_done", busy, 1);
      end
    end
    if (drp_rdy === 1'b1) chk("pll_rst_at_rdy", pll_rst, 1);
    if (pll_rst === 1'b1 && pll_rst_prev === 1'b0) t_rst_rise = cyc;
    if (pll_rst === 1'b0 && pll_rst_prev === 1'b1) t_rst_fall = cyc;
    if (pll_rst === 1'b1) begin rst_hi_seen = 1; lock_seen = 0; end
    else if (pll_locked && !lock_seen) begin t_lock = cyc; lock_seen = 1; end
    pll_rst_prev = pll_rst;
  end

  // DRP responder: DRDY one cycle after each DEN, reg1 at even, reg2 at odd addresses.
  bit hold_wr1 = 0, drop_wr2 = 0;
  logic [15:0] rd1_val = '0, rd2_val = '0;

  initial begin : responder
    logic [15:0] v;
    forever begin
      @(negedge refclk);
      if (drp_en === 1'b1 && !(hold_wr1 && drp_we && !drp_addr[0]) &&
          !(drop_wr2 && drp_we && drp_addr[0])) begin
        v = drp_we ? 16'h0 : (drp_addr[0] ? rd2_val : rd1_val);
        @(posedge refclk); #1;
        drp_rdy = 1'b1; drp_rdata = v;
        @(posedge refclk); #1;
        drp_rdy = 1'b0; drp_rdata = 16'h0;
      end
    end
  end

  // PLL lock model: LOCKED rises lock_delay+1 cycles after reset drops; -1 never locks.
  int lock_delay = 3;
  initial begin : lock_model
    int lcnt;
    lcnt = 0;
    forever begin
      @(posedge refclk); #2;
      if (pll_rst !== 1'b0) begin lcnt = 0; pll_locked = 1'b0; end
      else begin lcnt++; pll_locked = (lock_delay >= 0) && (lcnt > lock_delay); end
    end
  end

  task automatic tick();
    @(negedge refclk); #2;
  endtask

  task automatic request(input logic [2:0] sel, input logic [7:0] div, output int acc);
    int n;
    n = 0;
    first_en_seen = 0; rst_hi_seen = 0;
    tick();
    cfg_valid = 1'b1; cfg_sel = sel; cfg_divide = div;
    while (!cfg_ready && n < 50) begin tick(); n++; end
    if (n >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL request_accept: cfg_ready stayed 0 for %0d cycles", n);
    end
    acc = cyc;
    @(posedge refclk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string name);
    int n;
    n = 0;
    while (n_done == d0 && n < 300) begin tick(); n++; end
    if (n >= 300) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, n);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int acc, d0;
    rd1_val = v.rd1; rd2_val = v.rd2;
    push_accesses(v);
    push(2, 7'h0, 16'h0, 1'b0);
    d0 = n_done;
    request(v.sel, v.div, acc);
    wait_done(d0, "valid");
    chk("t_pll_rst_rise", t_rst_rise - acc, 1);
    chk("t_first_en", t_first_en - acc, 2);
    chk("t_pll_rst_fall", t_rst_fall - acc, 10);
    chk("t_done_after_lock", t_done - t_lock, 1);
    tick();
    chk("cfg_ready_after_done", cfg_ready, 1);
  endtask

  vec_t vecs [0:6];
  vec_t bad  [0:2];

  initial begin
    int acc, d0, a0, n;
    // high=D>>1, low=D-high (mod 64); reg1 keeps [15:12], reg2 keeps [15:8].
    // D=1: high=0, low=1; D=64: 32/32; D=127: 63/64->0; D=128: 64/64 -> 0/0.
    vecs = '{
      '{3'd0, 8'd25,  16'hF041, 16'hFFC3, 7'h08, 16'hF30D, 16'hFF80},
      '{3'd2, 8'd1,   16'h0000, 16'h0000, 7'h0C, 16'h0001, 16'h00C0},
      '{3'd6, 8'd128, 16'hFFFF, 16'hFFFF, 7'h14, 16'hF000, 16'hFF00},
      '{3'd5, 8'd2,   16'h1234, 16'hABCD, 7'h06, 16'h1041, 16'hAB00},
      '{3'd3, 8'd7,   16'h5AAA, 16'h00FF, 7'h0E, 16'h50C4, 16'h0080},
      '{3'd1, 8'd64,  16'h0FFF, 16'h1234, 7'h0A, 16'h0820, 16'h1200},
      '{3'd4, 8'd127, 16'hA000, 16'h3355, 7'h10, 16'hAFC0, 16'h3380}
    };
    bad = '{
      '{3'd7, 8'd25,  16'h0, 16'h0, 7'h0, 16'h0, 16'h0},
      '{3'd0, 8'd0,   16'h0, 16'h0, 7'h0, 16'h0, 16'h0},
      '{3'd1, 8'd129, 16'h0, 16'h0, 7'h0, 16'h0, 16'h0}
    };

    // Reset values
    repeat (3) @(posedge refclk);
    tick();
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_drp_en", drp_en, 0);
    chk("rst_drp_we", drp_we, 0);
    chk("rst_drp_addr", drp_addr, 0);
    chk("rst_drp_di", drp_di, 0);
    @(posedge refclk); #1;
    rst = 1'b0;
    @(posedge refclk);
    tick();
    chk("post_rst_cfg_ready", cfg_ready, 1);
    chk("post_rst_pll_rst", pll_rst, 0);

    // Valid requests with zero-wait DRP
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Invalid requests: done+err the next cycle, no DRP, PLL reset untouched
    for (int i = 0; i < 3; i++) begin
      push(2, 7'h0, 16'h0, 1'b1);
      d0 = n_done;
      request(bad[i].sel, bad[i].div, acc);
      wait_done(d0, "invalid");
      chk("invalid_done_latency", t_done - acc, 1);
      chk("invalid_pll_rst_seen", rst_hi_seen, 0);
      chk("invalid_drp_en_seen", first_en_seen, 0);
    end

    // Lock timeout
    lock_delay = -1;
    rd1_val = vecs[0].rd1; rd2_val = vecs[0].rd2;
    push_accesses(vecs[0]);
    push(2, 7'h0, 16'h0, 1'b1);
    d0 = n_done;
    request(vecs[0].sel, vecs[0].div, acc);
    wait_done(d0, "lock_tmo");
    chk("lock_tmo_latency", t_done - t_rst_fall, LOCK_TO);
    lock_delay = 3;

    // DRDY never arrives on the reg2 write
    drop_wr2 = 1;
    rd1_val = vecs[3].rd1; rd2_val = vecs[3].rd2;
    push_accesses(vecs[3]);
    push(2, 7'h0, 16'h0, 1'b1);
    d0 = n_done;
    request(vecs[3].sel, vecs[3].div, acc);
    wait_done(d0, "drp_tmo");
    chk("drp_tmo_latency", t_done - t_wr2, DRDY_TO + 2);
    drop_wr2 = 0;
    tick();
    chk("drp_tmo_cfg_ready", cfg_ready, 1);

    // Reset during WR1_W
    hold_wr1 = 1;
    rd1_val = 16'h0; rd2_val = 16'h0;
    push(0, 7'h0C, 16'h0, 1'b0);
    push(1, 7'h0C, 16'h0001, 1'b0);
    d0 = n_done;
    a0 = n_access;
    request(3'd2, 8'd1, acc);
    n = 0;
    while (n_access < a0 + 2 && n < 50) begin tick(); n++; end
    chk("rst_mid_reached_wr1", n_access - a0, 2);
    @(posedge refclk); #1;
    rst = 1'b1;
    @(posedge refclk); #1;
    rst = 1'b0;
    tick();
    chk("rst_mid_drp_en", drp_en, 0);
    chk("rst_mid_drp_we", drp_we, 0);
    chk("rst_mid_pll_rst", pll_rst, 1);
    chk("rst_mid_busy", busy, 0);
    repeat (5) tick();
    chk("rst_mid_no_done", n_done - d0, 0);
    chk("rst_mid_sb_empty", sb.size(), 0);
    hold_wr1 = 0;
    run_vec(vecs[3]);

    repeat (5) tick();
    chk("sb_empty_at_end", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
